// File: rtl/read_write_logic_8259.sv
// 8259 bus interface: qualifies RD/WR accesses, captures write data and A0, and pulses one
// decode strobe when a write ends. Define READ_WRITE_LOGIC_8259_INPUT_SYNC_EN for a two-flop input synchronizer.
module read_write_logic_8259 (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       chip_select_n,
  input  logic       read_enable_n,
  input  logic       write_enable_n,
  input  logic       address,
  input  logic [7:0] data_bus_in,
  output logic [7:0] internal_data_bus,
  output logic       write_initial_command_word_1,
  output logic       write_initial_command_word_2_4,
  output logic       write_operation_control_word_1,
  output logic       write_operation_control_word_2,
  output logic       write_operation_control_word_3,
  output logic       read,
  output logic       write
);

  // Access protocol: a write is the interval where CS_n and WR_n are both low, and it
  // completes when either pin rises. Write has priority when RD_n and WR_n overlap.
  logic write_req;
  logic read_req;

  assign write_req = ~chip_select_n & ~write_enable_n;
  assign read_req  = ~chip_select_n & ~read_enable_n & ~write_req;

  logic write_stage;
  logic read_stage;

`ifdef READ_WRITE_LOGIC_8259_INPUT_SYNC_EN
  logic write_meta;
  logic read_meta;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      write_meta  <= 1'b0;
      read_meta   <= 1'b0;
      write_stage <= 1'b0;
      read_stage  <= 1'b0;
    end else begin
      write_meta  <= write_req;
      read_meta   <= read_req;
      write_stage <= write_meta;
      read_stage  <= read_meta;
    end
  end
`else
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      write_stage <= 1'b0;
      read_stage  <= 1'b0;
    end else begin
      write_stage <= write_req;
      read_stage  <= read_req;
    end
  end
`endif

  assign write = write_stage;
  assign read  = read_stage;

  // Capture follows the qualified write level, so the last captured value is the one
  // present on the bus when the end of the write was sampled.
  logic captured_a0;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      internal_data_bus <= 8'h00;
      captured_a0       <= 1'b0;
    end else if (write_stage) begin
      internal_data_bus <= data_bus_in;
      captured_a0       <= address;
    end
  end

  logic write_prev;
  logic end_of_write;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      write_prev <= 1'b0;
    end else begin
      write_prev <= write_stage;
    end
  end

  assign end_of_write = write_prev & ~write_stage;

  // Bit order: {icw1, icw2_4, ocw1, ocw2, ocw3}
  logic [4:0] strobe_next;
  logic [4:0] strobe_q;

  always_comb begin
    strobe_next = 5'b00000;
    if (end_of_write) begin
      if (captured_a0) begin
        strobe_next = 5'b01100;
      end else if (internal_data_bus[4]) begin
        strobe_next = 5'b10000;
      end else if (internal_data_bus[3]) begin
        strobe_next = 5'b00001;
      end else begin
        strobe_next = 5'b00010;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      strobe_q <= 5'b00000;
    end else begin
      strobe_q <= strobe_next;
    end
  end

  assign write_initial_command_word_1   = strobe_q[4];
  assign write_initial_command_word_2_4 = strobe_q[3];
  assign write_operation_control_word_1 = strobe_q[2];
  assign write_operation_control_word_2 = strobe_q[1];
  assign write_operation_control_word_3 = strobe_q[0];

endmodule

// File: tb/tb_read_write_logic_8259.sv
// Bench for read_write_logic_8259: access-level reference model checked every cycle,
// plus directed bus accesses with hand-computed strobe counts, latencies and data.
module tb_read_write_logic_8259;

`ifdef READ_WRITE_LOGIC_8259_INPUT_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       clock          = 1'b0;
  logic       reset_n        = 1'b0;
  logic       chip_select_n  = 1'b1;
  logic       read_enable_n  = 1'b1;
  logic       write_enable_n = 1'b1;
  logic       address        = 1'b0;
  logic [7:0] data_bus_in    = 8'h00;
  logic [7:0] internal_data_bus;
  logic       icw1, icw2_4, ocw1, ocw2, ocw3;
  logic       read, write;
  logic [4:0] dut_strb;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  read_write_logic_8259 dut (
    .clock                          (clock),
    .reset_n                        (reset_n),
    .chip_select_n                  (chip_select_n),
    .read_enable_n                  (read_enable_n),
    .write_enable_n                 (write_enable_n),
    .address                        (address),
    .data_bus_in                    (data_bus_in),
    .internal_data_bus              (internal_data_bus),
    .write_initial_command_word_1   (icw1),
    .write_initial_command_word_2_4 (icw2_4),
    .write_operation_control_word_1 (ocw1),
    .write_operation_control_word_2 (ocw2),
    .write_operation_control_word_3 (ocw3),
    .read                           (read),
    .write                          (write)
  );

  assign dut_strb = {icw1, icw2_4, ocw1, ocw2, ocw3};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Which strobe group a completed write selects, from A0 and the data bits.
  function automatic logic [4:0] decode(input logic a0, input logic [7:0] d);
    if (a0)        return 5'b01100;
    else if (d[4]) return 5'b10000;
    else if (d[3]) return 5'b00001;
    else           return 5'b00010;
  endfunction

  // Reference model: the qualified level trails the pins by LAT edges, data is taken
  // while the level is high, and one strobe follows each falling level.
  logic       m_write = 0, m_read = 0, m_write_old = 0;
  logic       m_wreq = 0, m_rreq = 0, m_wreq_d = 0, m_rreq_d = 0;
  logic       m_a0 = 0;
  logic [7:0] m_data = 8'h00;
  logic [4:0] m_strb = 5'b0;

  initial forever begin
    @(posedge clock or negedge reset_n);
    if (!reset_n) begin
      m_write = 0; m_read = 0; m_write_old = 0; m_wreq_d = 0; m_rreq_d = 0;
      m_a0 = 0; m_data = 8'h00; m_strb = 5'b0;
    end else begin
      m_wreq = !chip_select_n && !write_enable_n;
      m_rreq = !chip_select_n && !read_enable_n && !m_wreq;
      m_strb = (m_write_old && !m_write) ? decode(m_a0, m_data) : 5'b0;
      if (m_write) begin
        m_data = data_bus_in;
        m_a0   = address;
      end
      m_write_old = m_write;
      if (LAT == 1) begin
        m_write = m_wreq;
        m_read  = m_rreq;
      end else begin
        m_write = m_wreq_d;
        m_read  = m_rreq_d;
      end
      m_wreq_d = m_wreq;
      m_rreq_d = m_rreq;
    end
  end

  initial forever begin
    @(posedge clock);
    #1;
    check("cyc write", write, m_write);
    check("cyc read", read, m_read);
    check("cyc data", internal_data_bus, m_data);
    check("cyc strobes", dut_strb, m_strb);
  end

  // Observation window: per-strobe high-cycle count and first cycle seen (1 = first edge).
  int w_cnt[5];
  int w_first[5];
  int w_rd, w_wr;

  task automatic watch(input int n);
    for (int i = 0; i < 5; i++) begin
      w_cnt[i] = 0;
      w_first[i] = -1;
    end
    w_rd = 0;
    w_wr = 0;
    for (int c = 1; c <= n; c++) begin
      @(posedge clock);
      #1;
      for (int i = 0; i < 5; i++) begin
        if (dut_strb[i]) begin
          w_cnt[i]++;
          if (w_first[i] < 0) w_first[i] = c;
        end
      end
      if (read) w_rd++;
      if (write) w_wr++;
    end
  endtask

  task automatic check_window(input string tag, input logic [4:0] exp_vec, input logic [7:0] exp_data,
                              input bit check_lat);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("%s count[%0d]", tag, i), w_cnt[i], exp_vec[i] ? 1 : 0);
      if (check_lat && exp_vec[i])
        check($sformatf("%s latency[%0d]", tag, i), w_first[i], LAT + 1);
    end
    check($sformatf("%s data", tag), internal_data_bus, exp_data);
  endtask

  task automatic write_access(input logic a0, input logic [7:0] d, input int cyc);
    @(negedge clock);
    chip_select_n = 0; address = a0; data_bus_in = d; write_enable_n = 0;
    repeat (cyc) @(negedge clock);
    write_enable_n = 1;
    watch(6);
    @(negedge clock);
    chip_select_n = 1;
  endtask

  int rd_total;

  initial begin
    #1;
    check("reset write", write, 0);
    check("reset read", read, 0);
    check("reset data", internal_data_bus, 8'h00);
    check("reset strobes", dut_strb, 5'b0);
    repeat (2) @(negedge clock);
    reset_n = 1;

    write_access(1'b0, 8'h13, 3);
    check_window("icw1", 5'b10000, 8'h13, 1);

    write_access(1'b1, 8'h20, 2);
    check_window("icw2_4/ocw1", 5'b01100, 8'h20, 1);

    write_access(1'b0, 8'h20, 2);
    check_window("ocw2", 5'b00010, 8'h20, 1);

    write_access(1'b0, 8'h0B, 2);
    check_window("ocw3", 5'b00001, 8'h0B, 1);

    // Read of four sampled cycles
    @(negedge clock);
    chip_select_n = 0; read_enable_n = 0;
    watch(4);
    rd_total = w_rd;
    check_window("read a", 5'b0, 8'h0B, 0);
    @(negedge clock);
    read_enable_n = 1;
    watch(4);
    rd_total += w_rd;
    check("read cycles", rd_total, 4);
    check_window("read b", 5'b0, 8'h0B, 0);
    chip_select_n = 1;

    // RD and WR overlap: write wins
    @(negedge clock);
    chip_select_n = 0; address = 0; data_bus_in = 8'h55; read_enable_n = 0; write_enable_n = 0;
    watch(3);
    check("overlap read", read, 0);
    check("overlap write", write, 1);
    @(negedge clock);
    read_enable_n = 1; write_enable_n = 1;
    watch(6);
    check_window("overlap", 5'b10000, 8'h55, 1);
    chip_select_n = 1;

    // CS_n rises before WR_n
    @(negedge clock);
    chip_select_n = 0; address = 0; data_bus_in = 8'h0B; write_enable_n = 0;
    repeat (2) @(negedge clock);
    chip_select_n = 1;
    watch(6);
    @(negedge clock);
    write_enable_n = 1;
    check_window("cs first", 5'b00001, 8'h0B, 1);

    // WR_n toggling while deselected
    data_bus_in = 8'h13;
    fork
      watch(10);
      begin
        for (int k = 0; k < 4; k++) begin
          @(negedge clock); write_enable_n = 0;
          @(negedge clock); write_enable_n = 1;
        end
      end
    join
    check("deselected write", w_wr, 0);
    check_window("deselected", 5'b0, 8'h0B, 0);

    // Write pulse entirely between two clock edges
    @(negedge clock);
    #1 chip_select_n = 0; write_enable_n = 0;
    #2 write_enable_n = 1; chip_select_n = 1;
    watch(5);
    check("short write", w_wr, 0);
    check_window("short", 5'b0, 8'h0B, 0);

    // Back-to-back writes, second begins in the strobe cycle of the first
    fork
      watch(12);
      begin
        @(negedge clock);
        chip_select_n = 0; address = 0; data_bus_in = 8'h13; write_enable_n = 0;
        repeat (2) @(negedge clock);
        write_enable_n = 1;
        @(negedge clock);
        data_bus_in = 8'h0B; write_enable_n = 0;
        repeat (2) @(negedge clock);
        write_enable_n = 1;
      end
    join
    chip_select_n = 1;
    check_window("back to back", 5'b10001, 8'h0B, 0);

    // Reset asserted in the middle of a write
    @(negedge clock);
    chip_select_n = 0; address = 0; data_bus_in = 8'hFF; write_enable_n = 0;
    repeat (3) @(negedge clock);
    check("pre-reset data", internal_data_bus, 8'hFF);
    #2 reset_n = 0;
    #1;
    check("async reset write", write, 0);
    check("async reset data", internal_data_bus, 8'h00);
    check("async reset strobes", dut_strb, 5'b0);
    @(negedge clock);
    write_enable_n = 1; chip_select_n = 1;
    @(negedge clock);
    reset_n = 1;
    watch(6);
    check_window("after reset", 5'b0, 8'h00, 0);

    repeat (2) @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/read_write_logic_8259.md
READ_WRITE_LOGIC_8259 -- requirements
Module: read_write_logic_8259

Interface
REQ-001 SHALL have port: clock  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port: reset_n  input  1  asynchronous active-low reset.
REQ-003 SHALL have port: chip_select_n  input  1  active-low chip select pin.
REQ-004 SHALL have port: read_enable_n  input  1  active-low RD pin.
REQ-005 SHALL have port: write_enable_n  input  1  active-low WR pin.
REQ-006 SHALL have port: address  input  1  A0 pin.
REQ-007 SHALL have port: data_bus_in  input  8  CPU write data.
REQ-008 SHALL have port: internal_data_bus  output  8  last captured write data, feeds control logic.
REQ-009 SHALL have ports: write_initial_command_word_1, write_initial_command_word_2_4, write_operation_control_word_1, write_operation_control_word_2, write_operation_control_word_3  output  1 each  one-cycle decode strobes.
REQ-010 SHALL have ports: read, write  output  1 each  registered levels of qualified read/write access.

Function
REQ-011 SHALL form write_req = ~chip_select_n & ~write_enable_n; read_req = ~chip_select_n & ~read_enable_n & ~write_req (write wins on overlap).
REQ-012 SHALL register write_req/read_req through the input stage (REQ-025/026); write and read outputs equal the final stage.
REQ-013 SHALL capture data_bus_in into internal_data_bus and address into an internal A0 register on every cycle the final-stage write is 1; values held otherwise.
REQ-014 SHALL detect end of write as final-stage write 1->0 (WR_n or chip_select_n rising, whichever first) and assert exactly one strobe group for exactly one cycle on the next clock edge.
REQ-015 SHALL decode from captured A0/data: A0=0 & D4=1 -> write_initial_command_word_1.
REQ-016 SHALL decode A0=1 -> write_initial_command_word_2_4 and write_operation_control_word_1 together (control logic selects by its command state).
REQ-017 SHALL decode A0=0 & D4=0 & D3=0 -> write_operation_control_word_2; A0=0 & D4=0 & D3=1 -> write_operation_control_word_3.
REQ-018 SHALL keep internal_data_bus stable during the strobe cycle and until the next write capture.
REQ-019 SHALL generate no strobe for read accesses, WR_n toggling with chip_select_n high, or write shorter than one sampled cycle.
REQ-020 SHALL hold every strobe at 0 on all cycles not covered by REQ-014; at most one strobe group per write access.
REQ-021 SHALL allow back-to-back writes: a new write beginning in the strobe cycle is captured normally.

Reset
REQ-022 SHALL, while reset_n=0, immediately force internal_data_bus=8'h00, captured A0=0, all strobes=0, read=0, write=0, all input stages to inactive.
REQ-023 SHALL generate no strobe from a write interrupted by reset; a write held active across reset release is treated as a new access.
REQ-024 SHALL require no clock for reset to take effect.

Configuration
REQ-025 SHALL, with macro READ_WRITE_LOGIC_8259_INPUT_SYNC_EN defined, pass write_req/read_req through a two-flop synchronizer: pin change sampled at edge E0 appears on write/read at E1; strobe at E2.
REQ-026 SHALL, without the macro, use a single register stage: change visible at E0, strobe at E1; decode and reset behaviour otherwise identical.

Verification
REQ-027 SHALL test: CS_n=0, A0=0, data 8'h13, WR_n low 3 cycles then high -> single one-cycle write_initial_command_word_1, internal_data_bus=8'h13, other strobes 0, latency per REQ-025/026.
REQ-028 SHALL test: A0=1, data 8'h20 write -> write_initial_command_word_2_4 and write_operation_control_word_1 high same single cycle; internal_data_bus=8'h20.
REQ-029 SHALL test: A0=0 data 8'h20 -> write_operation_control_word_2 only; then A0=0 data 8'h0B -> write_operation_control_word_3 only.
REQ-030 SHALL test: RD_n low 4 cycles -> read=1 for 4 cycles, no strobes; RD_n and WR_n low together -> read=0, write=1.
REQ-031 SHALL test: WR_n low, CS_n raised first -> exactly one strobe; WR_n toggled with CS_n=1 -> no strobes, write=0.
REQ-032 SHALL test: reset_n pulsed low mid-write (data 8'hFF) -> outputs 0 asynchronously, no strobe after release, internal_data_bus=8'h00.
